// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the SPU front-end fetch sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    RESET_WAIT,
    RUN,
    STALL,
    FLUSH,
    HALT
  } fetch_state_t;

  localparam int unsigned PAIR_BYTES   = 8;
  localparam int unsigned SLOT_SEL_BIT = 29;

  // Drops the slot-select and byte-offset bits to get the pair base address.
  function automatic logic [0:31] pairAlign(input logic [0:31] addr);
    return {addr[0:28], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control and fetch-address bundle between the sequencer and the decode/execute side.
interface fetch_sequencer_if;

  logic        stall_in;
  logic        branch_taken;
  logic [0:31] branch_target;
  logic [0:31] pc_out;
  logic        fetch_valid;
  logic        slot0_kill;
  logic        flush;
  logic        halted;
  logic        misalign_err;
  logic [0:15] pair_count;

  modport master (
    output stall_in, branch_taken, branch_target,
    input  pc_out, fetch_valid, slot0_kill, flush, halted, misalign_err, pair_count
  );

  modport slave (
    input  stall_in, branch_taken, branch_target,
    output pc_out, fetch_valid, slot0_kill, flush, halted, misalign_err, pair_count
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the dual-issue front end: sequential pair fetch,
// stall hold, branch redirect with slot-0 kill and one-cycle flush.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 2048,
  parameter logic [0:31] RESET_PC   = 32'h0000_0000
) (
  input logic             clock,
  input logic             reset,
  fetch_sequencer_if.slave fetchBus
);

  fetch_state_t state_q, state_d;
  logic [0:31]  pc_q, pc_d;
  logic         fetchValid_q, fetchValid_d;
  logic         slot0Kill_q, slot0Kill_d;
  logic         flush_q, flush_d;
  logic         halted_q, halted_d;
  logic         misalign_q, misalign_d;
  logic [0:15]  pairCount_q, pairCount_d;

  logic [0:31]  targetPair;
  logic [0:31]  pcAdvance;

  assign targetPair = pairAlign(fetchBus.branch_target);
  assign pcAdvance  = pc_q + 32'(PAIR_BYTES);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetchValid_d = fetchValid_q;
    slot0Kill_d  = slot0Kill_q;
    flush_d      = 1'b0;
    halted_d     = halted_q;
    misalign_d   = misalign_q;
    pairCount_d  = pairCount_q;

    if (fetchValid_q && (pairCount_q != 16'hFFFF)) begin
      pairCount_d = pairCount_q + 16'd1;
    end

    // A redirect outranks every state, including STALL and HALT.
    if (fetchBus.branch_taken) begin
      pc_d        = targetPair;
      slot0Kill_d = fetchBus.branch_target[SLOT_SEL_BIT];
      flush_d     = 1'b1;
      if (fetchBus.branch_target[30] || fetchBus.branch_target[31]) begin
        misalign_d = 1'b1;
      end
      if (targetPair >= 32'(IMEM_BYTES)) begin
        state_d      = HALT;
        fetchValid_d = 1'b0;
        halted_d     = 1'b1;
      end else begin
        state_d      = FLUSH;
        fetchValid_d = 1'b1;
        halted_d     = 1'b0;
      end
    end else begin
      case (state_q)
        RESET_WAIT: begin
          state_d      = RUN;
          fetchValid_d = 1'b1;
        end
        RUN, FLUSH: begin
          if (fetchBus.stall_in) begin
            state_d      = STALL;
            fetchValid_d = 1'b0;
          end else if (pcAdvance >= 32'(IMEM_BYTES)) begin
            state_d      = HALT;
            fetchValid_d = 1'b0;
            halted_d     = 1'b1;
            slot0Kill_d  = 1'b0;
          end else begin
            state_d      = RUN;
            pc_d         = pcAdvance;
            slot0Kill_d  = 1'b0;
            fetchValid_d = 1'b1;
          end
        end
        // Releasing a stall re-issues the held pair rather than skipping it.
        STALL: begin
          if (!fetchBus.stall_in) begin
            state_d      = RUN;
            fetchValid_d = 1'b1;
          end
        end
        HALT: begin
          fetchValid_d = 1'b0;
        end
        default: begin
          state_d      = HALT;
          fetchValid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= RESET_WAIT;
      pc_q         <= RESET_PC;
      fetchValid_q <= 1'b0;
      slot0Kill_q  <= 1'b0;
      flush_q      <= 1'b0;
      halted_q     <= 1'b0;
      misalign_q   <= 1'b0;
      pairCount_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetchValid_q <= fetchValid_d;
      slot0Kill_q  <= slot0Kill_d;
      flush_q      <= flush_d;
      halted_q     <= halted_d;
      misalign_q   <= misalign_d;
      pairCount_q  <= pairCount_d;
    end
  end

  assign fetchBus.pc_out       = pc_q;
  assign fetchBus.fetch_valid  = fetchValid_q;
  assign fetchBus.slot0_kill   = slot0Kill_q;
  assign fetchBus.flush        = flush_q;
  assign fetchBus.halted       = halted_q;
  assign fetchBus.misalign_err = misalign_q;
  assign fetchBus.pair_count   = pairCount_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table plus random
// stimulus against a flag-based behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam int unsigned IMEM = 2048;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        kill;
    logic        flush;
    logic        halted;
    logic        mis;
    logic [15:0] count;
  } outs_t;

  typedef struct packed {
    logic        stall;
    logic        branch;
    logic [31:0] target;
    outs_t       exp;
  } vec_t;

  logic clock;
  logic reset;
  int   compareCount;
  int   mismatchCount;

  fetch_sequencer_if fetchBus();

  fetch_sequencer #(
    .IMEM_BYTES(IMEM),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .fetchBus(fetchBus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: plain flags and arithmetic on byte addresses.
  logic [31:0] mPc;
  logic [15:0] mCount;
  bit mValid, mKill, mFlush, mHalted, mMis, mStarted, mStalled;

  task automatic modelReset();
    mPc = 32'h0; mCount = 16'h0;
    mValid = 0; mKill = 0; mFlush = 0; mHalted = 0; mMis = 0;
    mStarted = 0; mStalled = 0;
  endtask

  task automatic modelStep(input bit stall, input bit branch, input logic [31:0] target);
    logic [31:0] aligned;
    if (mValid && mCount != 16'hFFFF) mCount = mCount + 16'd1;
    mFlush = 0;
    if (branch) begin
      aligned  = target & ~32'h7;
      mPc      = aligned;
      mKill    = target[2];
      mFlush   = 1;
      if (target[1:0] != 2'b00) mMis = 1;
      mHalted  = (aligned >= IMEM);
      mValid   = !mHalted;
      mStalled = 0;
      mStarted = 1;
    end else if (!mStarted) begin
      mStarted = 1;
      mValid   = 1;
    end else if (mHalted) begin
      mValid = 0;
    end else if (mStalled) begin
      if (!stall) begin
        mStalled = 0;
        mValid   = 1;
      end
    end else if (stall) begin
      mStalled = 1;
      mValid   = 0;
    end else if (mPc + 8 >= IMEM) begin
      mHalted = 1;
      mValid  = 0;
      mKill   = 0;
    end else begin
      mPc    = mPc + 8;
      mKill  = 0;
      mValid = 1;
    end
  endtask

  function automatic outs_t modelOuts();
    outs_t o;
    o.pc = mPc; o.valid = mValid; o.kill = mKill; o.flush = mFlush;
    o.halted = mHalted; o.mis = mMis; o.count = mCount;
    return o;
  endfunction

  function automatic vec_t mk(input bit stall, input bit branch, input logic [31:0] target,
                              input logic [31:0] pc, input bit v, input bit k, input bit f,
                              input bit h, input bit m, input logic [15:0] cnt);
    vec_t r;
    r.stall = stall; r.branch = branch; r.target = target;
    r.exp.pc = pc; r.exp.valid = v; r.exp.kill = k; r.exp.flush = f;
    r.exp.halted = h; r.exp.mis = m; r.exp.count = cnt;
    return r;
  endfunction

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] actual, input logic [31:0] required);
    compareCount++;
    if (actual !== required) begin
      mismatchCount++;
      $display("[TB] FAIL %s %s: actual %h required %h", tag, field, actual, required);
    end
  endtask

  task automatic checkOutput(input string tag, input outs_t exp);
    checkField(tag, "pc_out",       32'(fetchBus.pc_out),       exp.pc);
    checkField(tag, "fetch_valid",  32'(fetchBus.fetch_valid),  32'(exp.valid));
    checkField(tag, "slot0_kill",   32'(fetchBus.slot0_kill),   32'(exp.kill));
    checkField(tag, "flush",        32'(fetchBus.flush),        32'(exp.flush));
    checkField(tag, "halted",       32'(fetchBus.halted),       32'(exp.halted));
    checkField(tag, "misalign_err", 32'(fetchBus.misalign_err), 32'(exp.mis));
    checkField(tag, "pair_count",   32'(fetchBus.pair_count),   32'(exp.count));
  endtask

  // Drives one cycle of inputs, then samples 1 ns after the rising edge.
  task automatic applyStimulus(input bit stall, input bit branch, input logic [31:0] target);
    fetchBus.stall_in      = stall;
    fetchBus.branch_taken  = branch;
    fetchBus.branch_target = target;
    @(posedge clock);
    #1;
  endtask

  vec_t  vecs[$];
  outs_t zeroOuts;

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    reset = 1'b0;
    fetchBus.stall_in      = 1'b0;
    fetchBus.branch_taken  = 1'b0;
    fetchBus.branch_target = 32'h0;
    zeroOuts = '0;

    //         stall br target         pc      v  k  f  h  m  count
    vecs.push_back(mk(0, 0, 32'h0,     32'h000, 1, 0, 0, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 32'h0,     32'h008, 1, 0, 0, 0, 0, 16'd1));
    vecs.push_back(mk(0, 0, 32'h0,     32'h010, 1, 0, 0, 0, 0, 16'd2));
    vecs.push_back(mk(0, 0, 32'h0,     32'h018, 1, 0, 0, 0, 0, 16'd3));
    vecs.push_back(mk(0, 0, 32'h0,     32'h020, 1, 0, 0, 0, 0, 16'd4));
    vecs.push_back(mk(0, 1, 32'h44,    32'h040, 1, 1, 1, 0, 0, 16'd5));
    vecs.push_back(mk(0, 0, 32'h0,     32'h048, 1, 0, 0, 0, 0, 16'd6));
    vecs.push_back(mk(0, 1, 32'h10,    32'h010, 1, 0, 1, 0, 0, 16'd7));
    vecs.push_back(mk(1, 0, 32'h0,     32'h010, 0, 0, 0, 0, 0, 16'd8));
    vecs.push_back(mk(1, 0, 32'h0,     32'h010, 0, 0, 0, 0, 0, 16'd8));
    vecs.push_back(mk(1, 0, 32'h0,     32'h010, 0, 0, 0, 0, 0, 16'd8));
    vecs.push_back(mk(0, 0, 32'h0,     32'h010, 1, 0, 0, 0, 0, 16'd8));
    vecs.push_back(mk(0, 0, 32'h0,     32'h018, 1, 0, 0, 0, 0, 16'd9));
    vecs.push_back(mk(1, 1, 32'h100,   32'h100, 1, 0, 1, 0, 0, 16'd10));
    vecs.push_back(mk(1, 0, 32'h0,     32'h100, 0, 0, 0, 0, 0, 16'd11));
    vecs.push_back(mk(0, 0, 32'h0,     32'h100, 1, 0, 0, 0, 0, 16'd11));
    vecs.push_back(mk(0, 1, 32'h7F0,   32'h7F0, 1, 0, 1, 0, 0, 16'd12));
    vecs.push_back(mk(0, 0, 32'h0,     32'h7F8, 1, 0, 0, 0, 0, 16'd13));
    vecs.push_back(mk(0, 0, 32'h0,     32'h7F8, 0, 0, 0, 1, 0, 16'd14));
    vecs.push_back(mk(1, 0, 32'h0,     32'h7F8, 0, 0, 0, 1, 0, 16'd14));
    vecs.push_back(mk(0, 1, 32'h8,     32'h008, 1, 0, 1, 0, 0, 16'd14));
    vecs.push_back(mk(0, 0, 32'h0,     32'h010, 1, 0, 0, 0, 0, 16'd15));
    vecs.push_back(mk(0, 1, 32'h23,    32'h020, 1, 0, 1, 0, 1, 16'd16));
    vecs.push_back(mk(0, 0, 32'h0,     32'h028, 1, 0, 0, 0, 1, 16'd17));
    vecs.push_back(mk(0, 1, 32'h64,    32'h060, 1, 1, 1, 0, 1, 16'd18));
    vecs.push_back(mk(0, 1, 32'h80,    32'h080, 1, 0, 1, 0, 1, 16'd19));
    vecs.push_back(mk(0, 0, 32'h0,     32'h088, 1, 0, 0, 0, 1, 16'd20));
    vecs.push_back(mk(0, 1, 32'h800,   32'h800, 0, 0, 1, 1, 1, 16'd21));
    vecs.push_back(mk(0, 0, 32'h0,     32'h800, 0, 0, 0, 1, 1, 16'd21));

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset", zeroOuts);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stall, vecs[i].branch, vecs[i].target);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset mid-run: outputs clear before the next edge.
    applyStimulus(0, 1, 32'h44);
    applyStimulus(0, 0, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("midReset", zeroOuts);
    #1;
    reset = 1'b1;
    applyStimulus(1, 0, 32'h0);
    checkOutput("resetWaitIgnoresStall", mk(0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 16'd0).exp);

    modelReset();
    modelStep(1, 0, 32'h0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit          stall;
      bit          branch;
      logic [31:0] target;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("randReset", modelOuts());
        #1;
        reset = 1'b1;
      end
      stall  = ($urandom_range(0, 3) == 0);
      branch = ($urandom_range(0, 9) == 0);
      target = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1984, 2100))
                                           : 32'($urandom_range(0, 2047));
      applyStimulus(stall, branch, target);
      modelStep(stall, branch, target);
      checkOutput($sformatf("rand%0d", cyc), modelOuts());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch sequencer for the dual-issue SPU front end. It owns the program counter and drives the fetch stage with pair-aligned addresses (8 bytes, two instructions per pair). Sources:
- sequential advance
- decode/hazard stalls
- branch redirects from the execute pipes

On a redirect it reports when slot 0 of the fetched pair must be turned into a no-op, because the branch target was the second word of its pair. It also pulses a flush that squashes the pair already in flight.

## Interface
Parameters:
- IMEM_BYTES, 2048, instruction memory size in bytes; must be a multiple of 8.
- RESET_PC, 0, first fetch address; must be 8-byte aligned.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall_in  input  1  hold request from decode/hazard logic.
- branch_taken  input  1  redirect request, single-cycle qualifier.
- branch_target  input  [0:31]  byte address of the branch target.
- pc_out  output  [0:31]  pair-aligned fetch address; bits [29:31] are always 0.
- fetch_valid  output  1  the fetch stage may consume pc_out this cycle.
- slot0_kill  output  1  first instruction of this pair is replaced by a no-op.
- flush  output  1  squash the pair fetched in the previous cycle.
- halted  output  1  sequential fetch ran off the end of memory.
- misalign_err  output  1  sticky; a branch_target with bits [30:31] ≠ 0 was received.
- pair_count  output  [0:15]  pairs issued (cycles with fetch_valid=1); saturates at 16'hFFFF.

## Operation
States: RESET_WAIT, RUN, STALL, FLUSH, HALT.

Reset values:
- pc_out=RESET_PC, fetch_valid=0, slot0_kill=0, flush=0, halted=0, misalign_err=0, pair_count=0.
- State is RESET_WAIT.

Priority (highest first): branch_taken, then stall_in, then sequential advance. A branch always wins, including in STALL and HALT.

Redirect (branch_taken=1):
- pc_out ← {branch_target[0:28], 3'b000}.
- slot0_kill ← branch_target[29].
- flush ← 1 for exactly one cycle.
- fetch_valid ← 1.
- State → FLUSH.
- Target bits [30:31] are ignored for addressing. If either is 1, misalign_err is set.
- If the aligned target is ≥ IMEM_BYTES, enter HALT instead: fetch_valid=0, halted=1, flush still pulses.

State behaviour:
- RESET_WAIT: always moves to RUN on the next cycle. fetch_valid=1 and pc_out=RESET_PC in that RUN cycle.
- RUN / FLUSH, no stall: pc_out += 8, slot0_kill ← 0, flush ← 0.
  - If pc_out+8 ≥ IMEM_BYTES, enter HALT: fetch_valid=0, halted=1, pc_out held.
- RUN / FLUSH with stall_in=1: enter STALL. pc_out, slot0_kill held; fetch_valid ← 0; flush ← 0.
- STALL: stays while stall_in=1. When stall_in=0, return to RUN with fetch_valid=1 and the same pc_out, so the held pair is re-fetched and not skipped.
- HALT: only a branch leaves it (halted ← 0), or reset. stall_in is ignored.

Other rules:
- pair_count increments on each cycle with fetch_valid=1 and stops at 16'hFFFF.
- Reset asserted mid-operation forces all reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- Latency from any input to its effect is one cycle.
- Branch at edge t: pc_out = target pair and flush=1 during cycle t+1; sequential pc_out+8 at t+2.
- A back-to-back branch in the FLUSH cycle redirects again; flush stays high a second cycle.
- stall_in sampled high at edge t: fetch_valid=0 from t+1. stall_in released at edge u: fetch_valid=1 from u+1.
- No combinational path from any input to any output.

## Structure
- Add to package descriptions:
  - fetch_state_t enum with the five states.
  - PAIR_BYTES = 8.
  - SLOT_SEL_BIT = 29.
- Single module; no sub-modules.
- Next-PC selection is a priority mux in always_comb. State, PC, flags and counter live in one always_ff with asynchronous reset on negedge reset.

## Test plan
- Reset release, no stall: pc_out sequence 0, 8, 16, 24; fetch_valid=1 from the second cycle; pair_count=4 after four issue cycles.
- Branch to 32'h0000_0044: next cycle pc_out=32'h40, slot0_kill=1, flush=1; following cycle pc_out=32'h48, slot0_kill=0, flush=0.
- stall_in high 3 cycles at pc_out=32'h10: fetch_valid=0 for 3 cycles, pc_out stays 32'h10; on release fetch_valid=1 with pc_out=32'h10, then 32'h18.
- branch_taken and stall_in together, target 32'h100: branch wins, pc_out=32'h100, flush=1; state then goes to STALL if stall_in is still high.
- Run to pc_out=2040: next cycle halted=1, fetch_valid=0; a branch to 32'h8 clears halted and resumes at 32'h8.
- Branch target 32'h0000_0023: pc_out=32'h20, slot0_kill=0, misalign_err=1 and it stays set until reset; reset asserted mid-run zeroes all outputs within the same cycle.
